// File: rtl/simd_lockstep_alu_hs.sv
// simd_lockstep_alu_hs: LANES-wide lockstep ALU (ADD/SUB/MUL/DIV/REM/MIN/MAX/PASS) with valid/ready handshakes.
// Define SIMD_ALU_MULHI_EN to add the result_hi port carrying the upper MUL product bits.
module simd_lockstep_alu_hs #(
  parameter int unsigned LANES     = 4,
  parameter int unsigned BIT_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 op_code,
  input  logic [LANES-1:0]           lane_en,
  input  logic [LANES*BIT_WIDTH-1:0] a,
  input  logic [LANES*BIT_WIDTH-1:0] b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*BIT_WIDTH-1:0] result,
  output logic [LANES-1:0]           div_by_zero,
`ifdef SIMD_ALU_MULHI_EN
  output logic [LANES*BIT_WIDTH-1:0] result_hi,
`endif
  output logic                       busy
);

  localparam int unsigned W  = BIT_WIDTH;
  localparam int unsigned W2 = 2 * BIT_WIDTH;
  localparam int unsigned CW = $clog2(BIT_WIDTH + 1);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_REM  = 3'd4;
  localparam logic [2:0] OP_MIN  = 3'd5;
  localparam logic [2:0] OP_MAX  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [2:0]            r_op;
  logic [LANES-1:0]      r_en;
  logic [W-1:0]          r_opa [LANES];
  logic [W-1:0]          r_opb [LANES];
  logic [W2-1:0]         r_acc [LANES];
  logic [LANES*W-1:0]    r_result;
  logic [LANES-1:0]      r_dz;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic                  r_busy;
`ifdef SIMD_ALU_MULHI_EN
  logic [LANES*W-1:0]    r_result_hi;
  logic [LANES*W-1:0]    w_result_hi;
`endif

  logic                  w_long;
  logic                  w_last;
  logic [W:0]            w_hi_sum  [LANES];
  logic [W:0]            w_rem_sh  [LANES];
  logic                  w_ge      [LANES];
  logic [W-1:0]          w_rem_new [LANES];
  logic [W2-1:0]         w_acc_nxt [LANES];
  logic [W-1:0]          w_opa_nxt [LANES];
  logic [W-1:0]          w_opb_nxt [LANES];
  logic [LANES*W-1:0]    w_result;
  logic [LANES-1:0]      w_dz;

  assign w_long = (r_op == OP_MUL) || (r_op == OP_DIV) || (r_op == OP_REM);
  // EXEC runs N iterations and one finalize cycle that publishes the lane results.
  assign w_last = (r_cnt == (w_long ? CW'(W) : CW'(1)));

  always_comb begin
    w_result = '0;
    w_dz     = '0;
`ifdef SIMD_ALU_MULHI_EN
    w_result_hi = '0;
`endif
    for (int unsigned i = 0; i < LANES; i++) begin
      w_hi_sum[i]  = {1'b0, r_acc[i][W2-1:W]} + (r_opb[i][0] ? {1'b0, r_opa[i]} : '0);
      w_rem_sh[i]  = {r_acc[i][W2-1:W], r_opa[i][W-1]};
      w_ge[i]      = (w_rem_sh[i] >= {1'b0, r_opb[i]});
      w_rem_new[i] = W'(w_ge[i] ? (w_rem_sh[i] - {1'b0, r_opb[i]}) : w_rem_sh[i]);
      w_acc_nxt[i] = r_acc[i];
      w_opa_nxt[i] = r_opa[i];
      w_opb_nxt[i] = r_opb[i];
      case (r_op)
        // Shift-add: add A at the top, shift product right; multiplier consumed LSB first.
        OP_MUL: begin
          w_acc_nxt[i] = {w_hi_sum[i], r_acc[i][W-1:1]};
          w_opb_nxt[i] = r_opb[i] >> 1;
        end
        // Restoring division: remainder in the upper half, quotient shifts into the lower half.
        OP_DIV, OP_REM: begin
          w_acc_nxt[i] = {w_rem_new[i], r_acc[i][W-2:0], w_ge[i]};
          w_opa_nxt[i] = r_opa[i] << 1;
        end
        OP_ADD:  w_acc_nxt[i] = {W'(0), W'(r_opa[i] + r_opb[i])};
        OP_SUB:  w_acc_nxt[i] = {W'(0), W'(r_opa[i] + ~r_opb[i] + W'(1))};
        OP_MIN:  w_acc_nxt[i] = {W'(0), (r_opa[i] < r_opb[i]) ? r_opa[i] : r_opb[i]};
        OP_MAX:  w_acc_nxt[i] = {W'(0), (r_opa[i] > r_opb[i]) ? r_opa[i] : r_opb[i]};
        OP_PASS: w_acc_nxt[i] = {W'(0), r_opa[i]};
        default: w_acc_nxt[i] = r_acc[i];
      endcase
      if (r_en[i]) begin
        w_result[i*W +: W] = (r_op == OP_REM) ? r_acc[i][W2-1:W] : r_acc[i][W-1:0];
        w_dz[i]            = ((r_op == OP_DIV) || (r_op == OP_REM)) && (r_opb[i] == '0);
`ifdef SIMD_ALU_MULHI_EN
        w_result_hi[i*W +: W] = (r_op == OP_MUL) ? r_acc[i][W2-1:W] : '0;
`endif
      end
    end
  end

  // Controller and lane registers; all handshake outputs are registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_op        <= OP_ADD;
      r_en        <= '0;
      r_result    <= '0;
      r_dz        <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef SIMD_ALU_MULHI_EN
      r_result_hi <= '0;
`endif
      for (int unsigned i = 0; i < LANES; i++) begin
        r_opa[i] <= '0;
        r_opb[i] <= '0;
        r_acc[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op       <= op_code;
            r_en       <= lane_en;
            r_cnt      <= '0;
            r_state    <= S_EXEC;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            for (int unsigned i = 0; i < LANES; i++) begin
              r_opa[i] <= a[i*W +: W];
              r_opb[i] <= b[i*W +: W];
              r_acc[i] <= '0;
            end
          end
        end
        S_EXEC: begin
          if (w_last) begin
            r_result    <= w_result;
            r_dz        <= w_dz;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
`ifdef SIMD_ALU_MULHI_EN
            r_result_hi <= w_result_hi;
`endif
          end else begin
            r_cnt <= r_cnt + CW'(1);
            for (int unsigned i = 0; i < LANES; i++) begin
              r_opa[i] <= w_opa_nxt[i];
              r_opb[i] <= w_opb_nxt[i];
              r_acc[i] <= w_acc_nxt[i];
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign busy        = r_busy;
  assign result      = r_result;
  assign div_by_zero = r_dz;
`ifdef SIMD_ALU_MULHI_EN
  assign result_hi   = r_result_hi;
`endif

endmodule

// File: tb/tb_simd_lockstep_alu_hs.sv
// Testbench for simd_lockstep_alu_hs (LANES=4, BIT_WIDTH=32): directed table, random vs. arithmetic model,
// back-pressure and mid-operation reset sequences. Honours SIMD_ALU_MULHI_EN when defined.
module tb_simd_lockstep_alu_hs;

  localparam int unsigned L = 4;
  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           in_valid;
  logic           in_ready;
  logic [2:0]     op_code;
  logic [L-1:0]   lane_en;
  logic [L*W-1:0] a;
  logic [L*W-1:0] b;
  logic           out_valid;
  logic           out_ready;
  logic [L*W-1:0] result;
  logic [L-1:0]   div_by_zero;
  logic           busy;
  logic [L*W-1:0] result_hi;

  simd_lockstep_alu_hs #(.LANES(L), .BIT_WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_code(op_code), .lane_en(lane_en), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .div_by_zero(div_by_zero),
`ifdef SIMD_ALU_MULHI_EN
    .result_hi(result_hi),
`endif
    .busy(busy)
  );

`ifndef SIMD_ALU_MULHI_EN
  assign result_hi = '0;
`endif

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [L*W-1:0] res;
    logic [L-1:0]   dz;
    logic [L*W-1:0] hi;
  } exp_t;

  typedef struct {
    logic [2:0]     op;
    logic [L-1:0]   en;
    logic [L*W-1:0] av;
    logic [L*W-1:0] bv;
    logic [L*W-1:0] res;
    logic [L-1:0]   dz;
    logic [L*W-1:0] hi;
    int             lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [L*W-1:0] act, input logic [L*W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference results straight from the arithmetic definition of each opcode.
  function automatic exp_t model(input logic [2:0] op, input logic [L-1:0] en,
                                 input logic [L*W-1:0] av, input logic [L*W-1:0] bv);
    exp_t e;
    e = '0;
    for (int i = 0; i < L; i++) begin
      logic [W-1:0]   x, y, r, h;
      logic [2*W-1:0] p;
      x = av[i*W +: W];
      y = bv[i*W +: W];
      p = {32'd0, x} * {32'd0, y};
      r = '0;
      h = '0;
      if (en[i]) begin
        case (op)
          3'd0: r = x + y;
          3'd1: r = x - y;
          3'd2: begin r = p[W-1:0]; h = p[2*W-1:W]; end
          3'd3: begin if (y == 0) begin r = '1; e.dz[i] = 1'b1; end else r = x / y; end
          3'd4: begin if (y == 0) begin r = x;  e.dz[i] = 1'b1; end else r = x % y; end
          3'd5: r = (x < y) ? x : y;
          3'd6: r = (x > y) ? x : y;
          default: r = x;
        endcase
      end
      e.res[i*W +: W] = r;
      e.hi[i*W +: W]  = h;
    end
    return e;
  endfunction

  // Issue one request, scramble inputs after acceptance, measure latency, capture and retire result.
  task automatic do_op(input logic [2:0] op, input logic [L-1:0] en,
                       input logic [L*W-1:0] av, input logic [L*W-1:0] bv,
                       output logic [L*W-1:0] res, output logic [L-1:0] dz,
                       output logic [L*W-1:0] hi, output int lat);
    int waits;
    waits = 0;
    while (!in_ready && waits < 50) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!in_ready) chk("in_ready_timeout", {127'd0, in_ready}, 1);
    op_code = op; lane_en = en; a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_code = 3'($urandom); lane_en = 4'($urandom);
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    chk("busy_exec", {127'd0, busy}, 1);
    chk("in_ready_exec", {127'd0, in_ready}, 0);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 100);
    res = result; dz = div_by_zero; hi = result_hi;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_retired", {127'd0, out_valid}, 0);
  endtask

  initial begin
    logic [L*W-1:0] res, hi, av, bv, held;
    logic [L-1:0]   dz, en;
    logic [2:0]     op;
    int             lat, rsel;
    exp_t           e;

    vecs[0]  = '{3'd0, 4'b1111, {32'd0, 32'd0, 32'hFFFF_FFFF, 32'd3}, {32'd0, 32'd0, 32'd1, 32'd5},
                 {32'd0, 32'd0, 32'd0, 32'd8}, 4'b0000, '0, 2};
    vecs[1]  = '{3'd1, 4'b1111, {32'd0, 32'd0, 32'hFFFF_FFFF, 32'd3}, {32'd0, 32'd0, 32'd1, 32'd5},
                 {32'd0, 32'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFE}, 4'b0000, '0, 2};
    vecs[2]  = '{3'd2, 4'b1111, {4{32'hFFFF_FFFF}}, {4{32'd2}},
                 {4{32'hFFFF_FFFE}}, 4'b0000, {4{32'd1}}, 33};
    vecs[3]  = '{3'd3, 4'b1111, {4{32'd100}}, {4{32'd7}}, {4{32'd14}}, 4'b0000, '0, 33};
    vecs[4]  = '{3'd4, 4'b1111, {4{32'd100}}, {4{32'd7}}, {4{32'd2}}, 4'b0000, '0, 33};
    vecs[5]  = '{3'd3, 4'b1111, {4{32'd100}}, {32'd7, 32'd0, 32'd7, 32'd7},
                 {32'd14, 32'hFFFF_FFFF, 32'd14, 32'd14}, 4'b0100, '0, 33};
    vecs[6]  = '{3'd4, 4'b1111, {4{32'd100}}, {32'd7, 32'd0, 32'd7, 32'd7},
                 {32'd2, 32'd100, 32'd2, 32'd2}, 4'b0100, '0, 33};
    vecs[7]  = '{3'd6, 4'b0101, {4{32'd9}}, {4{32'd12}}, {32'd0, 32'd12, 32'd0, 32'd12}, 4'b0000, '0, 2};
    vecs[8]  = '{3'd5, 4'b1111, {32'd5, 32'd0, 32'hFFFF_FFFF, 32'd9}, {32'd5, 32'd1, 32'd3, 32'd12},
                 {32'd5, 32'd0, 32'd3, 32'd9}, 4'b0000, '0, 2};
    vecs[9]  = '{3'd7, 4'b1010, {32'd4, 32'd3, 32'd2, 32'd1}, {4{32'd77}},
                 {32'd4, 32'd0, 32'd2, 32'd0}, 4'b0000, '0, 2};
    vecs[10] = '{3'd2, 4'b0000, {4{32'hFFFF_FFFF}}, {4{32'hFFFF_FFFF}}, '0, 4'b0000, '0, 33};

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_code = '0; lane_en = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {127'd0, in_ready}, 1);
    chk("rst_out_valid", {127'd0, out_valid}, 0);
    chk("rst_busy", {127'd0, busy}, 0);
    chk("rst_result", result, '0);
    chk("rst_dz", {124'd0, div_by_zero}, '0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 11; k++) begin
      do_op(vecs[k].op, vecs[k].en, vecs[k].av, vecs[k].bv, res, dz, hi, lat);
      chk($sformatf("vec%0d_result", k), res, vecs[k].res);
      chk($sformatf("vec%0d_dz", k), {124'd0, dz}, {124'd0, vecs[k].dz});
      chk($sformatf("vec%0d_latency", k), 128'(lat), 128'(vecs[k].lat));
`ifdef SIMD_ALU_MULHI_EN
      chk($sformatf("vec%0d_hi", k), hi, vecs[k].hi);
`endif
    end

    for (int k = 0; k < 40; k++) begin
      op = 3'($urandom_range(0, 7));
      en = 4'($urandom);
      for (int i = 0; i < L; i++) begin
        av[i*W +: W] = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 300);
        rsel = $urandom_range(0, 4);
        bv[i*W +: W] = (rsel == 0) ? 32'd0 : (rsel == 1) ? $urandom_range(1, 20) : $urandom;
      end
      e = model(op, en, av, bv);
      do_op(op, en, av, bv, res, dz, hi, lat);
      chk($sformatf("rnd%0d_op%0d_result", k, op), res, e.res);
      chk($sformatf("rnd%0d_op%0d_dz", k, op), {124'd0, dz}, {124'd0, e.dz});
      chk($sformatf("rnd%0d_op%0d_latency", k, op), 128'(lat), (op >= 3'd2 && op <= 3'd4) ? 128'd33 : 128'd2);
`ifdef SIMD_ALU_MULHI_EN
      chk($sformatf("rnd%0d_op%0d_hi", k, op), hi, e.hi);
`endif
    end

    // Back-pressure: DONE holds while out_ready is low, and ignores a pending request.
    op_code = 3'd6; lane_en = 4'b0101; a = {4{32'd9}}; b = {4{32'd12}}; in_valid = 1'b1;
    @(posedge clk); #1;
    a = {4{32'd1}}; b = {4{32'd1}}; op_code = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("bp_valid_at_2", {127'd0, out_valid}, 1);
    held = {32'd0, 32'd12, 32'd0, 32'd12};
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp%0d_out_valid", c), {127'd0, out_valid}, 1);
      chk($sformatf("bp%0d_in_ready", c), {127'd0, in_ready}, 0);
      chk($sformatf("bp%0d_result", c), result, held);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_valid", {127'd0, out_valid}, 0);
    chk("bp_release_in_ready", {127'd0, in_ready}, 1);
    chk("bp_release_busy", {127'd0, busy}, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("idle_result_held", result, held);
    chk("idle_no_accept", {127'd0, busy}, 0);

    // Asynchronous reset at MUL iteration 10, then a normal ADD.
    op_code = 3'd2; lane_en = 4'b1111; a = {4{32'hFFFF_FFFF}}; b = {4{32'd2}}; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_result", result, '0);
    chk("midrst_dz", {124'd0, div_by_zero}, '0);
    chk("midrst_out_valid", {127'd0, out_valid}, 0);
    chk("midrst_busy", {127'd0, busy}, 0);
    chk("midrst_in_ready", {127'd0, in_ready}, 1);
`ifdef SIMD_ALU_MULHI_EN
    chk("midrst_hi", result_hi, '0);
`endif
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    do_op(3'd0, 4'b1111, {32'd10, 32'd20, 32'hFFFF_FFFF, 32'd3}, {32'd1, 32'd2, 32'd1, 32'd5},
          res, dz, hi, lat);
    chk("post_rst_add_result", res, {32'd11, 32'd22, 32'd0, 32'd8});
    chk("post_rst_add_latency", 128'(lat), 128'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
